// File: rtl/counter_nbit.sv
// counter_nbit: parametrised up/down counter with a runtime terminal value.
// It can wrap or saturate, and has a synchronous clear and a parallel load.
// It drives a registered wrap pulse and two combinational status flags:
// at-limit and compare-match.
module counter_nbit #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_sat,
  input  logic [WIDTH-1:0] i_max,
  input  logic [WIDTH-1:0] i_cmp_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap,
  output logic             o_at_limit,
  output logic             o_match
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Operation selected for the coming edge, after the clear/load/step priority.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } op_e;

  op_e              op;
  logic             up_limit;
  logic             down_limit;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

  // A loaded count above i_max counts as already past the upper limit.
  assign up_limit   = (o_count >= i_max);
  assign down_limit = (o_count == ZERO);

  // Priority decode: clear beats load, and load beats an enabled step.
  // Reset is handled in the register itself, so it beats all three.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    op = OP_HOLD;
    if (i_clear) begin
      op = OP_CLEAR;
    end else if (i_load) begin
      op = OP_LOAD;
    end else if (i_en) begin
      op = i_dir ? OP_UP : OP_DOWN;
    end
  end

  // Next count and wrap pulse for the selected operation.
  // In saturate mode a step at the limit simply holds and never wraps.
  always_comb begin
    next_count = o_count;
    next_wrap  = 1'b0;
    case (op)
      OP_CLEAR: next_count = ZERO;
      OP_LOAD:  next_count = i_load_val;
      OP_UP: begin
        if (!up_limit) begin
          next_count = o_count + ONE;
        end else if (!i_sat) begin
          next_count = ZERO;
          next_wrap  = 1'b1;
        end
      end
      OP_DOWN: begin
        // A count above i_max after a load still steps down by one.
        if (!down_limit) begin
          next_count = o_count - ONE;
        end else if (!i_sat) begin
          next_count = i_max;
          next_wrap  = 1'b1;
        end
      end
      default: next_count = o_count;
    endcase
  end

  // State register: synchronous active-low reset, otherwise take the next state.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    if (!i_reset_n) begin
      o_count <= RESET_VAL;
      o_wrap  <= 1'b0;
    end else begin
      o_count <= next_count;
      o_wrap  <= next_wrap;
    end
  end

  // Status flags: combinational from the registered count and the live inputs.
  assign o_at_limit = i_dir ? up_limit : down_limit;
  assign o_match    = (o_count == i_cmp_val);

endmodule

// File: tb/tb_counter_nbit.sv
// tb_counter_nbit: directed steps from the test plan, then a randomized run.
// Every cycle is checked against a behavioural model of the counter.
module tb_counter_nbit;

  localparam int         W     = 8;
  localparam logic [7:0] RVAL  = 8'h5A;
  localparam int         RANGE = 256;

  logic         i_clk = 1'b0;
  logic         i_reset_n;
  logic         i_clear;
  logic         i_load;
  logic [W-1:0] i_load_val;
  logic         i_en;
  logic         i_dir;
  logic         i_sat;
  logic [W-1:0] i_max;
  logic [W-1:0] i_cmp_val;
  logic [W-1:0] o_count;
  logic         o_wrap;
  logic         o_at_limit;
  logic         o_match;

  int total = 0;
  int bad   = 0;

  // Model state.
  int m_count;
  int m_wrap;
  int n_count;
  int n_wrap;

  counter_nbit #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_clear    (i_clear),
    .i_load     (i_load),
    .i_load_val (i_load_val),
    .i_en       (i_en),
    .i_dir      (i_dir),
    .i_sat      (i_sat),
    .i_max      (i_max),
    .i_cmp_val  (i_cmp_val),
    .o_count    (o_count),
    .o_wrap     (o_wrap),
    .o_at_limit (o_at_limit),
    .o_match    (o_match)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model of one edge. It works on plain integers: an up step goes past the
  // terminal value when count+1 exceeds i_max, and a down step goes past it
  // when count-1 drops below zero.
  task automatic model_next();
    int nxt;
    n_count = m_count;
    n_wrap  = 0;
    if (!i_reset_n) begin
      n_count = int'(RVAL);
    end else if (i_clear) begin
      n_count = 0;
    end else if (i_load) begin
      n_count = int'(i_load_val);
    end else if (i_en) begin
      nxt = i_dir ? m_count + 1 : m_count - 1;
      if (nxt > int'(i_max) && i_dir) begin
        if (!i_sat) begin
          n_count = 0;
          n_wrap  = 1;
        end
      end else if (nxt < 0) begin
        if (!i_sat) begin
          n_count = int'(i_max);
          n_wrap  = 1;
        end
      end else begin
        n_count = nxt % RANGE;
      end
    end
  endtask

  task automatic check_model(input string tag);
    int lim;
    lim = i_dir ? int'(m_count >= int'(i_max)) : int'(m_count == 0);
    check({tag, ".count"},    32'(o_count),    32'(m_count));
    check({tag, ".wrap"},     32'(o_wrap),     32'(m_wrap));
    check({tag, ".at_limit"}, 32'(o_at_limit), 32'(lim));
    check({tag, ".match"},    32'(o_match),    32'(m_count == int'(i_cmp_val)));
  endtask

  // Advance one clock edge, update the model, and check the outputs 1 ns later.
  task automatic step(input string tag);
    model_next();
    @(posedge i_clk);
    #1;
    m_count = n_count;
    m_wrap  = n_wrap;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    i_reset_n = 1'b1; i_clear = 1'b0; i_load = 1'b0; i_en = 1'b0;
  endtask

  initial begin
    int first_wrap;
    int second_wrap;
    int nwraps;
    logic [7:0] seq_up [12];
    logic [7:0] seq_dn [3];
    logic [7:0] sat_up [5];

    m_count = 0; m_wrap = 0;
    i_reset_n = 1'b0; i_clear = 1'b0; i_load = 1'b0; i_load_val = 8'h00;
    i_en = 1'b1; i_dir = 1'b1; i_sat = 1'b0; i_max = 8'hFF; i_cmp_val = 8'h00;
    @(negedge i_clk);

    // Reset held for two cycles while the counter is enabled.
    step("rst0");
    step("rst1");
    check("reset_count", 32'(o_count), 32'h5A);
    check("reset_wrap",  32'(o_wrap),  32'h0);

    // Free count over the full range: wraps after 166 steps and 256 steps later.
    i_reset_n = 1'b1;
    first_wrap = -1; second_wrap = -1; nwraps = 0;
    for (int k = 1; k <= 430; k++) begin
      step("free");
      if (o_wrap) begin
        nwraps++;
        if (first_wrap < 0) first_wrap = k;
        else if (second_wrap < 0) second_wrap = k;
      end
      if (k == 166) begin
        check("free_166_count", 32'(o_count), 32'h00);
        check("free_166_wrap",  32'(o_wrap),  32'h1);
      end
    end
    check("free_first_wrap",  32'(first_wrap),  32'd166);
    check("free_second_wrap", 32'(second_wrap), 32'd422);
    check("free_num_wraps",   32'(nwraps),      32'd2);

    // Modulo-10 up then down.
    idle_inputs(); i_clear = 1'b1;
    step("m10_clr");
    i_clear = 1'b0; i_en = 1'b1; i_dir = 1'b1; i_sat = 1'b0; i_max = 8'd9;
    seq_up = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0, 8'd1, 8'd2};
    for (int k = 0; k < 12; k++) begin
      step("m10_up");
      check("m10_up_count", 32'(o_count), 32'(seq_up[k]));
      check("m10_up_wrap",  32'(o_wrap),  32'(seq_up[k] == 8'd0));
    end
    i_dir = 1'b0;
    seq_dn = '{8'd1, 8'd0, 8'd9};
    for (int k = 0; k < 3; k++) begin
      step("m10_dn");
      check("m10_dn_count", 32'(o_count), 32'(seq_dn[k]));
      check("m10_dn_wrap",  32'(o_wrap),  32'(seq_dn[k] == 8'd9));
    end

    // Saturate mode.
    idle_inputs(); i_sat = 1'b1; i_max = 8'h10; i_dir = 1'b1;
    i_load = 1'b1; i_load_val = 8'h0E;
    step("sat_load");
    i_load = 1'b0; i_en = 1'b1;
    sat_up = '{8'h0F, 8'h10, 8'h10, 8'h10, 8'h10};
    for (int k = 0; k < 5; k++) begin
      step("sat_up");
      check("sat_up_count", 32'(o_count),    32'(sat_up[k]));
      check("sat_up_limit", 32'(o_at_limit), 32'(k >= 1));
      check("sat_up_wrap",  32'(o_wrap),     32'h0);
    end
    idle_inputs(); i_load = 1'b1; i_load_val = 8'h01;
    step("sat_load1");
    i_load = 1'b0; i_en = 1'b1; i_dir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("sat_dn");
      check("sat_dn_count", 32'(o_count), 32'h00);
      check("sat_dn_wrap",  32'(o_wrap),  32'h0);
    end

    // Priority: clear > load > step, and reset beats everything.
    idle_inputs(); i_sat = 1'b0; i_max = 8'hFF; i_dir = 1'b1;
    i_load = 1'b1; i_load_val = 8'h33;
    step("pri_pre");
    i_clear = 1'b1; i_load = 1'b1; i_load_val = 8'hAA; i_en = 1'b1;
    step("pri_clr");
    check("pri_clear", 32'(o_count), 32'h00);
    i_clear = 1'b0;
    step("pri_load");
    check("pri_load", 32'(o_count), 32'hAA);
    i_reset_n = 1'b0; i_load_val = 8'h55;
    step("pri_rst");
    check("pri_reset", 32'(o_count), 32'h5A);

    // Load above the terminal value.
    idle_inputs(); i_max = 8'h20; i_sat = 1'b0;
    i_load = 1'b1; i_load_val = 8'h80;
    step("above_load");
    i_load = 1'b0; i_en = 1'b1; i_dir = 1'b1;
    step("above_up");
    check("above_up_count", 32'(o_count), 32'h00);
    check("above_up_wrap",  32'(o_wrap),  32'h1);
    idle_inputs(); i_load = 1'b1;
    step("above_reload");
    i_load = 1'b0; i_en = 1'b1; i_dir = 1'b0;
    step("above_dn");
    check("above_dn_count", 32'(o_count), 32'h7F);
    check("above_dn_wrap",  32'(o_wrap),  32'h0);

    // Compare flag, then the degenerate i_max = 0 case.
    idle_inputs(); i_clear = 1'b1; i_cmp_val = 8'h07; i_max = 8'hFF; i_dir = 1'b1;
    step("cmp_clr");
    check("cmp_at0", 32'(o_match), 32'h0);
    i_clear = 1'b0; i_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step("cmp_up");
      check("cmp_match", 32'(o_match), 32'(k == 7));
    end
    idle_inputs(); i_clear = 1'b1;
    step("max0_clr");
    i_clear = 1'b0; i_en = 1'b1; i_max = 8'h00; i_sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_dir = k[0];
      step("max0");
      check("max0_count", 32'(o_count), 32'h00);
      check("max0_wrap",  32'(o_wrap),  32'h1);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      i_reset_n  = ($urandom_range(0, 63) != 0);
      i_clear    = ($urandom_range(0, 31) == 0);
      i_load     = ($urandom_range(0, 15) == 0);
      i_load_val = 8'($urandom);
      i_en       = ($urandom_range(0, 3) != 0);
      i_dir      = 1'($urandom);
      i_sat      = ($urandom_range(0, 3) == 0);
      if (k % 16 == 0) begin
        case ($urandom_range(0, 3))
          0:       i_max = 8'h00;
          1:       i_max = 8'hFF;
          2:       i_max = 8'($urandom_range(1, 15));
          default: i_max = 8'($urandom);
        endcase
      end
      i_cmp_val = 8'($urandom_range(0, 31));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
